// File: rtl/if_stage.sv
// Instruction fetch stage: drives a sync-read imem, presents a registered instruction to ID, redirects on jumps.
// Latency: a read issued in cycle N shows up on instr/instr_valid/pc_out in cycle N+2; a taken jump costs 2 bubbles.
// Backpressure: stall freezes every register and drops imem_rd_en, so the memory holds the word already in flight.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   stall                         hold all fetch state this cycle
//   jenable, jop_lsb, addr        jump from ID (jop_lsb: 0 = J, 1 = JEQ), absolute target
//   cmp_flag                      last CMPEQ result, qualifies JEQ
//   imem_addr, imem_rd_en         instruction memory read port
//   imem_data                     memory read data (valid one edge after an enabled read)
//   instr, pc_out, instr_valid    registered instruction, its address, and bubble flag to ID
module if_stage #(
    parameter int ARQ = 16,
    parameter int AW  = 14
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           stall,
    input  logic           jenable,
    input  logic           jop_lsb,
    input  logic [AW-1:0]  addr,
    input  logic           cmp_flag,
    output logic [AW-1:0]  imem_addr,
    output logic           imem_rd_en,
    input  logic [ARQ-1:0] imem_data,
    output logic [ARQ-1:0] instr,
    output logic [AW-1:0]  pc_out,
    output logic           instr_valid
);

    typedef enum logic [0:0] {
        S_BOOT = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    localparam logic [AW-1:0] PC_ONE = {{(AW-1){1'b0}}, 1'b1};

    state_t         state_q, state_d;
    logic [AW-1:0]  fetch_pc_q, fetch_pc_d;
    logic           pend_q, pend_d;
    logic [AW-1:0]  pend_pc_q, pend_pc_d;
    logic [ARQ-1:0] instr_q, instr_d;
    logic [AW-1:0]  pc_out_q, pc_out_d;
    logic           instr_valid_q, instr_valid_d;

    logic run;
    logic taken;

    assign run = (state_q == S_RUN);

    // Only a jump carried by a real (non-bubble) instruction may redirect, and
    // never while stalled: a held jump is evaluated on its first free cycle.
    assign taken = run && !stall && instr_valid_q && jenable && (!jop_lsb || cmp_flag);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_BOOT;
            fetch_pc_q    <= '0;
            pend_q        <= 1'b0;
            pend_pc_q     <= '0;
            instr_q       <= '0;
            pc_out_q      <= '0;
            instr_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            fetch_pc_q    <= fetch_pc_d;
            pend_q        <= pend_d;
            pend_pc_q     <= pend_pc_d;
            instr_q       <= instr_d;
            pc_out_q      <= pc_out_d;
            instr_valid_q <= instr_valid_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        fetch_pc_d    = fetch_pc_q;
        pend_d        = pend_q;
        pend_pc_d     = pend_pc_q;
        instr_d       = instr_q;
        pc_out_d      = pc_out_q;
        instr_valid_d = instr_valid_q;

        case (state_q)
            // One idle cycle after reset so the first read is issued cleanly;
            // stall and jumps have no meaning yet.
            S_BOOT: begin
                state_d = S_RUN;
            end
            S_RUN: begin
                if (!stall) begin
                    if (taken) begin
                        // Drop the sequential read already in flight; the
                        // instruction/pc registers keep their (now stale) values.
                        fetch_pc_d    = addr;
                        pend_d        = 1'b0;
                        instr_valid_d = 1'b0;
                    end else begin
                        instr_d       = imem_data;
                        instr_valid_d = pend_q;
                        pc_out_d      = pend_pc_q;
                        pend_d        = 1'b1;
                        pend_pc_d     = fetch_pc_q;
                        fetch_pc_d    = fetch_pc_q + PC_ONE; // wraps modulo 2^AW
                    end
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    assign imem_addr   = fetch_pc_q;
    assign imem_rd_en  = run && !stall;
    assign instr       = instr_q;
    assign pc_out      = pc_out_q;
    assign instr_valid = instr_valid_q;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: table of per-cycle inputs and expected outputs, plus an async-reset-mid-redirect sequence.
// Memory model returns 16'hA000 + address, one edge after an enabled read, holding otherwise.
// Outputs are checked 2 time units after each rising edge; inputs change 1 unit after it.
module tb_if_stage;

    localparam int ARQ = 16;
    localparam int AW  = 14;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           stall = 1'b0;
    logic           jenable = 1'b0;
    logic           jop_lsb = 1'b0;
    logic [AW-1:0]  addr = '0;
    logic           cmp_flag = 1'b0;
    logic [AW-1:0]  imem_addr;
    logic           imem_rd_en;
    logic [ARQ-1:0] imem_data = '0;
    logic [ARQ-1:0] instr;
    logic [AW-1:0]  pc_out;
    logic           instr_valid;

    int total = 0;
    int bad   = 0;

    if_stage #(.ARQ(ARQ), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .stall       (stall),
        .jenable     (jenable),
        .jop_lsb     (jop_lsb),
        .addr        (addr),
        .cmp_flag    (cmp_flag),
        .imem_addr   (imem_addr),
        .imem_rd_en  (imem_rd_en),
        .imem_data   (imem_data),
        .instr       (instr),
        .pc_out      (pc_out),
        .instr_valid (instr_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (imem_rd_en) imem_data <= 16'hA000 + {2'b00, imem_addr};
    end

    typedef struct {
        logic          st;
        logic          jen;
        logic          jop;
        logic [AW-1:0] ja;
        logic          cmp;
        logic          ev;   // expected instr_valid
        logic [15:0]   ei;   // expected instr (checked only when ev)
        logic [AW-1:0] ep;   // expected pc_out (checked only when ev)
        logic          er;   // expected imem_rd_en
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic st, input logic jen, input logic jop,
                                input logic [AW-1:0] ja, input logic cmp, input logic ev,
                                input logic [15:0] ei, input logic [AW-1:0] ep, input logic er);
        vec_t v;
        v.st = st; v.jen = jen; v.jop = jop; v.ja = ja; v.cmp = cmp;
        v.ev = ev; v.ei = ei; v.ep = ep; v.er = er;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_instr"},     32'(instr),       32'h0);
        chk({tag, "_pc_out"},    32'(pc_out),      32'h0);
        chk({tag, "_valid"},     32'(instr_valid), 32'h0);
        chk({tag, "_rd_en"},     32'(imem_rd_en),  32'h0);
        chk({tag, "_imem_addr"}, 32'(imem_addr),   32'h0);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //             st   jen  jop  addr      cmp  ev   instr     pc        rd
        vecs.push_back(mk(1'b1,1'b1,1'b0,14'h0010,1'b0,1'b0,16'h0000,14'h0000,1'b0)); // 0 BOOT ignores stall/jump
        vecs.push_back(mk(1'b0,1'b0,1'b0,14'h0000,1'b0,1'b0,16'h0000,14'h0000,1'b1)); // 1 first read
        vecs.push_back(mk(1'b0,1'b0,1'b0,14'h0000,1'b0,1'b0,16'h0000,14'h0000,1'b1)); // 2
        vecs.push_back(mk(1'b0,1'b0,1'b0,14'h0000,1'b0,1'b1,16'hA000,14'h0000,1'b1)); // 3 first valid
        vecs.push_back(mk(1'b0,1'b0,1'b0,14'h0000,1'b0,1'b1,16'hA001,14'h0001,1'b1)); // 4
        vecs.push_back(mk(1'b0,1'b1,1'b0,14'h0005,1'b0,1'b1,16'hA002,14'h0002,1'b1)); // 5 J 5
        vecs.push_back(mk(1'b0,1'b0,1'b0,14'h0000,1'b0,1'b0,16'h0000,14'h0000,1'b1)); // 6 bubble
        vecs.push_back(mk(1'b0,1'b0,1'b0,14'h0000,1'b0,1'b0,16'h0000,14'h0000,1'b1)); // 7 bubble
        vecs.push_back(mk(1'b0,1'b0,1'b0,14'h0000,1'b0,1'b1,16'hA005,14'h0005,1'b1)); // 8
        vecs.push_back(mk(1'b1,1'b0,1'b0,14'h0000,1'b0,1'b1,16'hA006,14'h0006,1'b0)); // 9 stall x3
        vecs.push_back(mk(1'b1,1'b0,1'b0,14'h0000,1'b0,1'b1,16'hA006,14'h0006,1'b0)); // 10
        vecs.push_back(mk(1'b1,1'b0,1'b0,14'h0000,1'b0,1'b1,16'hA006,14'h0006,1'b0)); // 11
        vecs.push_back(mk(1'b0,1'b0,1'b0,14'h0000,1'b0,1'b1,16'hA006,14'h0006,1'b1)); // 12
        vecs.push_back(mk(1'b0,1'b0,1'b0,14'h0000,1'b0,1'b1,16'hA007,14'h0007,1'b1)); // 13
        vecs.push_back(mk(1'b0,1'b1,1'b1,14'h0004,1'b0,1'b1,16'hA008,14'h0008,1'b1)); // 14 JEQ not taken
        vecs.push_back(mk(1'b0,1'b1,1'b1,14'h0003,1'b1,1'b1,16'hA009,14'h0009,1'b1)); // 15 JEQ taken -> 3
        vecs.push_back(mk(1'b0,1'b0,1'b0,14'h0000,1'b0,1'b0,16'h0000,14'h0000,1'b1)); // 16 bubble
        vecs.push_back(mk(1'b0,1'b0,1'b0,14'h0000,1'b0,1'b0,16'h0000,14'h0000,1'b1)); // 17 bubble
        vecs.push_back(mk(1'b0,1'b0,1'b0,14'h0000,1'b0,1'b1,16'hA003,14'h0003,1'b1)); // 18
        vecs.push_back(mk(1'b0,1'b1,1'b0,14'h3FFE,1'b0,1'b1,16'hA004,14'h0004,1'b1)); // 19 J 3FFE
        vecs.push_back(mk(1'b0,1'b0,1'b0,14'h0000,1'b0,1'b0,16'h0000,14'h0000,1'b1)); // 20 bubble
        vecs.push_back(mk(1'b0,1'b0,1'b0,14'h0000,1'b0,1'b0,16'h0000,14'h0000,1'b1)); // 21 bubble
        vecs.push_back(mk(1'b0,1'b0,1'b0,14'h0000,1'b0,1'b1,16'hDFFE,14'h3FFE,1'b1)); // 22
        vecs.push_back(mk(1'b0,1'b0,1'b0,14'h0000,1'b0,1'b1,16'hDFFF,14'h3FFF,1'b1)); // 23
        vecs.push_back(mk(1'b0,1'b0,1'b0,14'h0000,1'b0,1'b1,16'hA000,14'h0000,1'b1)); // 24 wrapped
        vecs.push_back(mk(1'b1,1'b1,1'b0,14'h0010,1'b0,1'b1,16'hA001,14'h0001,1'b0)); // 25 jump held in stall
        vecs.push_back(mk(1'b1,1'b1,1'b0,14'h0010,1'b0,1'b1,16'hA001,14'h0001,1'b0)); // 26
        vecs.push_back(mk(1'b0,1'b1,1'b0,14'h0010,1'b0,1'b1,16'hA001,14'h0001,1'b1)); // 27 taken here
        vecs.push_back(mk(1'b0,1'b1,1'b0,14'h0010,1'b0,1'b0,16'h0000,14'h0000,1'b1)); // 28 jump on bubble ignored
        vecs.push_back(mk(1'b0,1'b1,1'b0,14'h0010,1'b0,1'b0,16'h0000,14'h0000,1'b1)); // 29
        vecs.push_back(mk(1'b0,1'b0,1'b0,14'h0000,1'b0,1'b1,16'hA010,14'h0010,1'b1)); // 30
        vecs.push_back(mk(1'b0,1'b0,1'b0,14'h0000,1'b0,1'b1,16'hA011,14'h0011,1'b1)); // 31

        // Outputs while reset is held.
        repeat (2) @(posedge clk);
        #2;
        chk_zero_outputs("in_reset");

        // Release reset just after an edge: this cycle is BOOT (row 0).
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < vecs.size(); i++) begin
            if (i > 0) next_cycle();
            stall    = vecs[i].st;
            jenable  = vecs[i].jen;
            jop_lsb  = vecs[i].jop;
            addr     = vecs[i].ja;
            cmp_flag = vecs[i].cmp;
            #1;
            chk($sformatf("row%0d_valid", i), 32'(instr_valid), 32'(vecs[i].ev));
            chk($sformatf("row%0d_rd_en", i), 32'(imem_rd_en),  32'(vecs[i].er));
            if (vecs[i].ev) begin
                chk($sformatf("row%0d_instr", i),  32'(instr),  32'(vecs[i].ei));
                chk($sformatf("row%0d_pc_out", i), 32'(pc_out), 32'(vecs[i].ep));
            end
        end

        // Taken jump at pc 0x11, then async reset in the first bubble cycle.
        jenable = 1'b1; jop_lsb = 1'b0; addr = 14'h0020; stall = 1'b0;
        next_cycle();
        jenable = 1'b0;
        #1;
        chk("redir_bubble_valid", 32'(instr_valid), 32'h0);
        chk("redir_fetch_addr",   32'(imem_addr),   32'h0020);
        chk("redir_pc_before_rst", 32'(pc_out),     32'h0011);
        #1;
        rst = 1'b1;   // mid-cycle, no clock edge involved
        #1;
        chk_zero_outputs("async_rst");

        @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("reboot_c0_rd_en", 32'(imem_rd_en), 32'h0);
        next_cycle(); #1;
        chk("reboot_c1_rd_en", 32'(imem_rd_en), 32'h1);
        chk("reboot_c1_addr",  32'(imem_addr),  32'h0);
        next_cycle(); #1;
        chk("reboot_c2_valid", 32'(instr_valid), 32'h0);
        next_cycle(); #1;
        chk("reboot_c3_valid", 32'(instr_valid), 32'h1);
        chk("reboot_c3_instr", 32'(instr),       32'hA000);
        chk("reboot_c3_pc",    32'(pc_out),      32'h0);
        next_cycle(); #1;
        chk("reboot_c4_instr", 32'(instr),       32'hA001);
        chk("reboot_c4_pc",    32'(pc_out),      32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
